// File: rtl/tlul_pkg.sv
// Minimal TL-UL type slice shared by the host adapters and device-side bridges.
`default_nettype none

package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [7:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

`default_nettype wire

// File: rtl/tlul_sram_bridge_pkg.sv
// Types and helpers for the TL-UL to single-port SRAM bridge.
`default_nettype none

package tlul_sram_bridge_pkg;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic        error;
    logic [31:0] data;
  } rsp_entry_t;

  typedef enum logic [2:0] {
    ErrNone,
    ErrOpcode,
    ErrSize,
    ErrAlign,
    ErrMask,
    ErrFullMask,
    ErrRange
  } err_cause_t;

  // Byte lanes a beat of the given size may touch at the given word offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      2'd0:    lane_mask = 4'b0001 << offset;
      2'd1:    lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlul_sram_bridge_if.sv
// TL-UL request/response pair between a host adapter and the SRAM bridge.
`default_nettype none

interface tlul_sram_bridge_if;

  tlul_pkg::tl_h2d_t tl_i;
  tlul_pkg::tl_d2h_t tl_o;

  modport master (output tl_i, input tl_o);
  modport slave  (input tl_i, output tl_o);

endinterface

`default_nettype wire

// File: rtl/tlul_sram_rsp_fifo.sv
// Synchronous-reset response FIFO; head is readable combinationally.
`default_nettype none

module tlul_sram_rsp_fifo
  import tlul_sram_bridge_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  rsp_entry_t    wdata,
  input  logic          pop,
  output rsp_entry_t    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  rsp_entry_t mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic pop_en;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_en = pop && !empty;
  assign rdata  = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop_en) begin
        rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      end
      case ({push, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/tlul_sram_bridge.sv
// TL-UL device bridge onto a 1-cycle-latency single-port word SRAM with buffered responses.
`default_nettype none

module tlul_sram_bridge
  import tlul_pkg::*;
  import tlul_sram_bridge_pkg::*;
#(
  parameter int SRAM_DEPTH          = 4096,
  parameter int OUTSTANDING         = 3,
  parameter bit ERR_ON_OUT_OF_RANGE = 1'b1,
  localparam int SRAM_AW            = $clog2(SRAM_DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tlul_sram_bridge_if.slave  tl,
  output logic               sram_req_o,
  output logic               sram_we_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  output logic [31:0]        sram_wmask_o,
  input  logic [31:0]        sram_rdata_i
);

  localparam int FIFO_DEPTH = OUTSTANDING - 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  tl_h2d_t    req;
  err_cause_t err_cause;
  logic       is_get, is_put, misaligned, out_of_range;
  logic [3:0] lanes;
  logic       a_ready, accept, d_valid, pop;

  assign req = tl.tl_i;

  always_comb begin
    is_get       = (req.a_opcode == Get);
    is_put       = (req.a_opcode == PutFullData) || (req.a_opcode == PutPartialData);
    lanes        = lane_mask(req.a_size, req.a_address[1:0]);
    misaligned   = ((req.a_size == 2'd1) && req.a_address[0]) ||
                   ((req.a_size == 2'd2) && (req.a_address[1:0] != 2'b00));
    out_of_range = (req.a_address >> 2) >= 32'(SRAM_DEPTH);
    err_cause    = ErrNone;
    if (!(is_get || is_put))                                          err_cause = ErrOpcode;
    else if (req.a_size > 2'd2)                                       err_cause = ErrSize;
    else if (misaligned)                                              err_cause = ErrAlign;
    else if (is_put && (((req.a_mask & ~lanes) != 4'h0) || (req.a_mask == 4'h0)))
                                                                      err_cause = ErrMask;
    else if ((req.a_opcode == PutFullData) && (req.a_mask != lanes))  err_cause = ErrFullMask;
    else if (ERR_ON_OUT_OF_RANGE && out_of_range)                     err_cause = ErrRange;
  end

  assign accept       = req.a_valid && a_ready;
  assign sram_req_o   = accept && (err_cause == ErrNone);
  assign sram_we_o    = !is_get;
  assign sram_addr_o  = req.a_address[SRAM_AW+1:2];
  assign sram_wdata_o = req.a_data;
  assign sram_wmask_o = {{8{req.a_mask[3]}}, {8{req.a_mask[2]}},
                         {8{req.a_mask[1]}}, {8{req.a_mask[0]}}};

  logic             stage_valid, stage_held, stage_error, stage_is_read, stage_push;
  logic [2:0]       stage_opcode;
  logic [1:0]       stage_size;
  logic [7:0]       stage_source;
  logic [31:0]      stage_data, live_data;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  rsp_entry_t       push_entry, head;

  assign a_ready    = rst_ni && ((32'(fifo_count) + 32'(stage_valid)) < 32'(OUTSTANDING));
  assign live_data  = (stage_is_read && !stage_error) ? sram_rdata_i : 32'h0;
  assign stage_push = stage_valid && (!fifo_full || pop);

  // With the FIFO full and no pop, the stage keeps its entry and latches the read data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_valid <= 1'b0;
      stage_held  <= 1'b0;
    end else begin
      if (stage_push) begin
        stage_valid <= 1'b0;
        stage_held  <= 1'b0;
      end else if (stage_valid) begin
        stage_held  <= 1'b1;
      end
      if (accept) begin
        stage_valid <= 1'b1;
        stage_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      stage_opcode  <= is_get ? AccessAckData : AccessAck;
      stage_size    <= req.a_size;
      stage_source  <= req.a_source;
      stage_error   <= (err_cause != ErrNone);
      stage_is_read <= is_get;
    end
    if (stage_valid && !stage_push && !stage_held) begin
      stage_data <= live_data;
    end
  end

  always_comb begin
    push_entry.opcode = stage_opcode;
    push_entry.size   = stage_size;
    push_entry.source = stage_source;
    push_entry.error  = stage_error;
    push_entry.data   = stage_held ? stage_data : live_data;
  end

  tlul_sram_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (stage_push),
    .wdata  (push_entry),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign d_valid = rst_ni && !fifo_empty;
  assign pop     = d_valid && req.d_ready;

  always_comb begin
    tl.tl_o         = '0;
    tl.tl_o.a_ready = a_ready;
    if (d_valid) begin
      tl.tl_o.d_valid  = 1'b1;
      tl.tl_o.d_opcode = head.opcode;
      tl.tl_o.d_size   = head.size;
      tl.tl_o.d_source = head.source;
      tl.tl_o.d_data   = head.data;
      tl.tl_o.d_error  = head.error;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tlul_sram_bridge.sv
// Directed self-checking bench for tlul_sram_bridge against a behavioural SRAM.
`default_nettype none
`timescale 1ns/1ps

module tb_tlul_sram_bridge;
  import tlul_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sram_req, sram_we;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata, sram_wmask, sram_rdata;
  logic [31:0] mem [4096];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk_i = ~clk_i;

  tlul_sram_bridge_if tl_bus ();

  tlul_sram_bridge dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tl           (tl_bus),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_wmask_o (sram_wmask),
    .sram_rdata_i (sram_rdata)
  );

  always @(posedge clk_i) begin
    if (sram_req) begin
      if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else         sram_rdata <= mem[sram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    tl_bus.tl_i.a_valid   = 1'b1;
    tl_bus.tl_i.a_opcode  = op;
    tl_bus.tl_i.a_size    = size;
    tl_bus.tl_i.a_source  = src;
    tl_bus.tl_i.a_address = addr;
    tl_bus.tl_i.a_mask    = mask;
    tl_bus.tl_i.a_data    = data;
  endtask

  // One beat; returns the SRAM strobe signals seen in the accept cycle.
  task automatic issue(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                       output logic req, output logic we, output logic [11:0] waddr,
                       output logic [31:0] wmask);
    int guard = 0;
    drive(op, size, src, addr, mask, data);
    #1;
    while (!tl_bus.tl_o.a_ready && guard < 20) begin
      @(posedge clk_i);
      #2;
      guard++;
    end
    if (guard >= 20) check_eq("issue_timeout", 64'(guard), 64'(0));
    req   = sram_req;
    we    = sram_we;
    waddr = sram_addr;
    wmask = sram_wmask;
    tick();
    tl_bus.tl_i.a_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [2:0] op, input logic err,
                            input logic [31:0] data, input logic [7:0] src,
                            input logic [1:0] size, output int lat);
    lat = 0;
    while (!tl_bus.tl_o.d_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_valid"}, 64'(tl_bus.tl_o.d_valid), 64'(1));
    check_eq({tag, "_rsp"},
             {6'b0, tl_bus.tl_o.d_opcode, tl_bus.tl_o.d_error, tl_bus.tl_o.d_size,
              tl_bus.tl_o.d_source, tl_bus.tl_o.d_param, tl_bus.tl_o.d_sink,
              tl_bus.tl_o.d_user, tl_bus.tl_o.d_data},
             {6'b0, op, err, size, src, 3'b0, 1'b0, 8'b0, data});
    tick();
  endtask

  logic        req, we;
  logic [11:0] waddr;
  logic [31:0] wmask;
  int          lat, drops, got_n, acc, stale;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | i;
    sram_rdata = '0;
    tl_bus.tl_i = '0;
    tl_bus.tl_i.d_ready = 1'b1;

    tick();
    tick();
    check_eq("rst_aready", 64'(tl_bus.tl_o.a_ready), 64'(0));
    check_eq("rst_dvalid", 64'(tl_bus.tl_o.d_valid), 64'(0));
    rst_ni = 1'b1;
    #1;
    check_eq("post_rst_aready", 64'(tl_bus.tl_o.a_ready), 64'(1));
    tick();

    // Full-word write then read-back with latency check.
    issue(PutFullData, 2'd2, 8'h01, 32'h10, 4'hF, 32'hDEAD_BEEF, req, we, waddr, wmask);
    check_eq("pf_sram", {req, we, waddr, wmask}, {1'b1, 1'b1, 12'd4, 32'hFFFF_FFFF});
    expect_rsp("pf", AccessAck, 1'b0, 32'h0, 8'h01, 2'd2, lat);
    issue(Get, 2'd2, 8'h02, 32'h10, 4'hF, 32'h0, req, we, waddr, wmask);
    check_eq("get_sram", {req, we, waddr}, {1'b1, 1'b0, 12'd4});
    expect_rsp("get", AccessAckData, 1'b0, 32'hDEAD_BEEF, 8'h02, 2'd2, lat);
    check_eq("get_latency", 64'(lat), 64'(1));

    // Partial halfword write into the upper lanes.
    issue(PutFullData, 2'd2, 8'h03, 32'h10, 4'hF, 32'h1122_3344, req, we, waddr, wmask);
    expect_rsp("pf2", AccessAck, 1'b0, 32'h0, 8'h03, 2'd2, lat);
    issue(PutPartialData, 2'd1, 8'h04, 32'h12, 4'hC, 32'hAAAA_0000, req, we, waddr, wmask);
    check_eq("pp_sram", {req, we, waddr, wmask}, {1'b1, 1'b1, 12'd4, 32'hFFFF_0000});
    expect_rsp("pp", AccessAck, 1'b0, 32'h0, 8'h04, 2'd1, lat);
    issue(Get, 2'd2, 8'h05, 32'h10, 4'hF, 32'h0, req, we, waddr, wmask);
    expect_rsp("pp_rd", AccessAckData, 1'b0, 32'hAAAA_3344, 8'h05, 2'd2, lat);

    // Illegal beats: no SRAM access, error response.
    issue(3'd7, 2'd2, 8'h31, 32'h20, 4'hF, 32'h0, req, we, waddr, wmask);
    check_eq("err_op_req", 64'(req), 64'(0));
    expect_rsp("err_op", AccessAck, 1'b1, 32'h0, 8'h31, 2'd2, lat);
    issue(Get, 2'd2, 8'h32, 32'h2, 4'hF, 32'h0, req, we, waddr, wmask);
    check_eq("err_align_req", 64'(req), 64'(0));
    expect_rsp("err_align", AccessAckData, 1'b1, 32'h0, 8'h32, 2'd2, lat);
    issue(PutFullData, 2'd0, 8'h33, 32'h1, 4'h1, 32'h0, req, we, waddr, wmask);
    check_eq("err_mask_req", 64'(req), 64'(0));
    expect_rsp("err_mask", AccessAck, 1'b1, 32'h0, 8'h33, 2'd0, lat);
    issue(Get, 2'd2, 8'h34, 32'h4000, 4'hF, 32'h0, req, we, waddr, wmask);
    check_eq("err_range_req", 64'(req), 64'(0));
    expect_rsp("err_range", AccessAckData, 1'b1, 32'h0, 8'h34, 2'd2, lat);

    // Sixteen back-to-back reads.
    drops = 0;
    got_n = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          drive(Get, 2'd2, 8'(8'h10 + i), 32'((8 + i) * 4), 4'hF, 32'h0);
          #1;
          if (!tl_bus.tl_o.a_ready) drops++;
          tick();
        end
        tl_bus.tl_i.a_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        for (int c = 0; c < 60 && n < 16; c++) begin
          @(negedge clk_i);
          if (tl_bus.tl_o.d_valid) begin
            check_eq("b2b_rsp", {tl_bus.tl_o.d_source, tl_bus.tl_o.d_data},
                     {8'(8'h10 + n), 32'hA500_0000 | 32'(8 + n)});
            n++;
          end
        end
        got_n = n;
      end
    join
    check_eq("b2b_drops", 64'(drops), 64'(0));
    check_eq("b2b_count", 64'(got_n), 64'(16));
    tick();

    // Back-pressure: capacity of three, then recovery after the first pop.
    tl_bus.tl_i.d_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(Get, 2'd2, 8'(8'h40 + acc), 32'((30 + acc) * 4), 4'hF, 32'h0);
      #1;
      if (tl_bus.tl_o.a_ready) acc++;
      tick();
    end
    check_eq("bp_accepts", 64'(acc), 64'(3));
    check_eq("bp_aready_low", 64'(tl_bus.tl_o.a_ready), 64'(0));
    tl_bus.tl_i.d_ready = 1'b1;
    #1;
    check_eq("bp_release_aready", 64'(tl_bus.tl_o.a_ready), 64'(0));
    expect_rsp("bp0", AccessAckData, 1'b0, 32'hA500_0000 | 32'd30, 8'h40, 2'd2, lat);
    check_eq("bp_recover", 64'(tl_bus.tl_o.a_ready), 64'(1));
    expect_rsp("bp1", AccessAckData, 1'b0, 32'hA500_0000 | 32'd31, 8'h41, 2'd2, lat);
    tl_bus.tl_i.a_valid = 1'b0;
    expect_rsp("bp2", AccessAckData, 1'b0, 32'hA500_0000 | 32'd32, 8'h42, 2'd2, lat);
    expect_rsp("bp3", AccessAckData, 1'b0, 32'hA500_0000 | 32'd33, 8'h43, 2'd2, lat);

    // Reset with two transactions in flight.
    tl_bus.tl_i.d_ready = 1'b0;
    drive(Get, 2'd2, 8'h50, 32'd32, 4'hF, 32'h0);
    tick();
    drive(Get, 2'd2, 8'h51, 32'd36, 4'hF, 32'h0);
    tick();
    tl_bus.tl_i.a_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_forced", {tl_bus.tl_o.a_ready, tl_bus.tl_o.d_valid}, 2'b00);
    tick();
    rst_ni = 1'b1;
    #1;
    check_eq("after_rst", {tl_bus.tl_o.a_ready, tl_bus.tl_o.d_valid}, 2'b10);
    tl_bus.tl_i.d_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (tl_bus.tl_o.d_valid) stale++;
    end
    check_eq("no_stale", 64'(stale), 64'(0));
    issue(Get, 2'd2, 8'h52, 32'd32, 4'hF, 32'h0, req, we, waddr, wmask);
    expect_rsp("post_rst_get", AccessAckData, 1'b0, 32'hA500_0008, 8'h52, 2'd2, lat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
